// File: rtl/enduro_fifo_rd_stream_if.sv
// Handshake bundle joining the read-stream engine to the FIFO controller, the memory read port
// and the AXI-Stream sink. The master modport is the engine side.
interface enduro_fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned LVL_WIDTH  = 2
);
    logic                  fifo_empty;
    logic                  inc_rd_pointer;
    logic                  rd_mem_en;
    logic [DATA_WIDTH-1:0] rd_mem_data;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [LVL_WIDTH-1:0]  buf_level;
    logic [CNT_WIDTH-1:0]  xfer_count;

    modport master (
        input  fifo_empty,
        input  rd_mem_data,
        input  m_axis_tready,
        output inc_rd_pointer,
        output rd_mem_en,
        output m_axis_tvalid,
        output m_axis_tdata,
        output buf_level,
        output xfer_count
    );

    modport slave (
        output fifo_empty,
        output rd_mem_data,
        output m_axis_tready,
        input  inc_rd_pointer,
        input  rd_mem_en,
        input  m_axis_tvalid,
        input  m_axis_tdata,
        input  buf_level,
        input  xfer_count
    );
endinterface

// File: rtl/enduro_fifo_rd_stream.sv
// Read-side egress engine: prefetches FIFO words through a fixed-latency memory into a small
// in-order buffer and presents them as an AXI-Stream master at up to one word per clock.
module enduro_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic                     m_axis_clk,
    input logic                     m_axis_reset,
    enduro_fifo_rd_stream_if.master bus
);
    localparam int unsigned BUF_DEPTH = READ_LATENCY + 1;
    localparam int unsigned LVL_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IDX_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W     = LVL_W + 1;

    logic [READ_LATENCY-1:0] inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]   buf_d [BUF_DEPTH];
    logic [IDX_W-1:0]        head_q, head_d;
    logic [IDX_W-1:0]        tail_q, tail_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [CNT_WIDTH-1:0]    xfer_q, xfer_d;

    logic             tvalid_c;
    logic             pop_c;
    logic             ret_c;
    logic             issue_c;
    logic [OCC_W-1:0] inflight_cnt_c;
    logic [OCC_W-1:0] occ_after_c;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Handshake and issue decision; occupancy counts buffered plus in-flight words after this pop
    always_comb begin
        tvalid_c       = (level_q != '0);
        pop_c          = tvalid_c & bus.m_axis_tready;
        ret_c          = inflight_q[READ_LATENCY-1];
        inflight_cnt_c = '0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight_cnt_c = inflight_cnt_c + OCC_W'(inflight_q[i]);
        end
        occ_after_c = OCC_W'(level_q) + inflight_cnt_c - OCC_W'(pop_c);
        issue_c     = ~m_axis_reset & ~bus.fifo_empty & (occ_after_c < OCC_W'(BUF_DEPTH));
    end

    // Next-state for tracker, buffer pointers, occupancy and transfer counter
    always_comb begin
        inflight_d = READ_LATENCY'({inflight_q, issue_c});
        head_d     = head_q;
        tail_d     = tail_q;
        level_d    = level_q + LVL_W'(ret_c) - LVL_W'(pop_c);
        xfer_d     = xfer_q + CNT_WIDTH'(pop_c);
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            buf_d[i] = buf_q[i];
        end
        if (ret_c) begin
            buf_d[tail_q] = bus.rd_mem_data;
            tail_d        = idx_inc(tail_q);
        end
        if (pop_c) begin
            head_d = idx_inc(head_q);
        end
    end

    // Reset discards buffered and returning words alike
    always_ff @(posedge m_axis_clk) begin
        if (m_axis_reset) begin
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            xfer_q     <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            level_q    <= level_d;
            xfer_q     <= xfer_d;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign bus.inc_rd_pointer = issue_c;
    assign bus.rd_mem_en      = issue_c;
    assign bus.m_axis_tvalid  = tvalid_c;
    assign bus.m_axis_tdata   = buf_q[head_q];
    assign bus.buf_level      = level_q;
    assign bus.xfer_count     = xfer_q;

endmodule
